// File: rtl/data_mem_io_pkg.sv
// Shared address map, STATUS bit layout and region decode for the data-side memory/IO stage.
package data_mem_io_pkg;

    localparam logic [31:0] RAM_BASE     = 32'h0000_0000;
    localparam logic [31:0] RAM_LIMIT    = 32'h0000_03FF;
    localparam logic [31:0] LED_ADDR     = 32'h0000_1000;
    localparam logic [31:0] SW_ADDR      = 32'h0000_1004;
    localparam logic [31:0] TX_DATA_ADDR = 32'h0000_1008;
    localparam logic [31:0] STATUS_ADDR  = 32'h0000_100C;
    localparam logic [31:0] CYCLE_ADDR   = 32'h0000_1010;

    localparam int STATUS_EMPTY_BIT = 0;
    localparam int STATUS_FULL_BIT  = 1;
    localparam int STATUS_OVF_BIT   = 2;
    localparam int STATUS_COUNT_LSB = 3;
    localparam int STATUS_COUNT_MSB = 7;

    typedef enum logic [2:0] {
        REG_RAM,
        REG_LED,
        REG_SW,
        REG_TX,
        REG_STATUS,
        REG_CYCLE,
        REG_NONE
    } region_t;

    // Byte-lane bits are dropped before matching, so any alignment hits the word.
    function automatic region_t decode_region(input logic [31:0] address);
        logic [31:0] word;
        word = {address[31:2], 2'b00};
        if (address[31:13] != '0) begin
            return REG_NONE;
        end
        if (word <= RAM_LIMIT) begin
            return REG_RAM;
        end
        case (word)
            LED_ADDR:     return REG_LED;
            SW_ADDR:      return REG_SW;
            TX_DATA_ADDR: return REG_TX;
            STATUS_ADDR:  return REG_STATUS;
            CYCLE_ADDR:   return REG_CYCLE;
            default:      return REG_NONE;
        endcase
    endfunction

    function automatic logic [7:0] ram_word_index(input logic [31:0] address);
        return 8'((address - RAM_BASE) >> 2);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through FIFO; head reads 0 while empty, pushes while full are refused.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr_reg];

    // Storage carries no reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/data_mem_io.sv
// Data-side stage of the single-cycle core: word RAM plus LED, switch, TX FIFO, STATUS and CYCLE registers.
module data_mem_io
    import data_mem_io_pkg::*;
#(
    parameter int RAM_WORDS  = 256,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_write,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    input  logic [15:0] sw,
    output logic [15:0] leds,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);
    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int CW     = $clog2(FIFO_DEPTH) + 1;

    region_t     region;
    logic [7:0]  ram_index;
    logic        ram_in_range;
    logic [31:0] ram_reg [RAM_WORDS];
    logic [15:0] leds_reg;
    logic [15:0] sw_meta_reg;
    logic [15:0] sw_sync_reg;
    logic        overflow_reg;
    logic [31:0] cycle_reg;
    logic        fifo_full;
    logic        fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [7:0]  fifo_head;
    logic        wr_ram;
    logic        wr_led;
    logic        wr_status;
    logic        wr_cycle;
    logic        push_req;
    logic        fifo_push;
    logic        fifo_pop;
    logic [31:0] status_word;

    assign region       = decode_region(address);
    assign ram_index    = ram_word_index(address);
    assign ram_in_range = (region == REG_RAM) && ({1'b0, ram_index} < 9'(RAM_WORDS));

    assign wr_ram    = mem_write && ram_in_range;
    assign wr_led    = mem_write && (region == REG_LED);
    assign wr_status = mem_write && (region == REG_STATUS);
    assign wr_cycle  = mem_write && (region == REG_CYCLE);
    assign push_req  = mem_write && (region == REG_TX);
    // A push against a full FIFO is dropped even if the consumer pops this cycle.
    assign fifo_push = push_req && !fifo_full;
    assign fifo_pop  = tx_valid && tx_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RAM_WORDS; i++) begin
                ram_reg[i] <= '0;
            end
        end else if (wr_ram) begin
            ram_reg[ram_index[RAM_AW-1:0]] <= write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            leds_reg     <= '0;
            sw_meta_reg  <= '0;
            sw_sync_reg  <= '0;
            overflow_reg <= 1'b0;
            cycle_reg    <= '0;
        end else begin
            sw_meta_reg <= sw;
            sw_sync_reg <= sw_meta_reg;
            if (wr_led) begin
                leds_reg <= write_data[15:0];
            end
            // Set beats clear when an overflow and a STATUS write coincide.
            if (push_req && fifo_full) begin
                overflow_reg <= 1'b1;
            end else if (wr_status) begin
                overflow_reg <= 1'b0;
            end
            cycle_reg <= wr_cycle ? '0 : cycle_reg + 32'd1;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (write_data[7:0]),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign tx_data  = fifo_head;
    assign tx_valid = !fifo_empty;
    assign leds     = leds_reg;

    always_comb begin
        status_word                                    = '0;
        status_word[STATUS_EMPTY_BIT]                  = fifo_empty;
        status_word[STATUS_FULL_BIT]                   = fifo_full;
        status_word[STATUS_OVF_BIT]                    = overflow_reg;
        status_word[STATUS_COUNT_MSB:STATUS_COUNT_LSB] = 5'(fifo_count);
    end

    // Zero-latency read path: the core expects load data in the same cycle.
    always_comb begin
        read_data = '0;
        case (region)
            REG_RAM:    read_data = ram_in_range ? ram_reg[ram_index[RAM_AW-1:0]] : '0;
            REG_LED:    read_data = {16'b0, leds_reg};
            REG_SW:     read_data = {16'b0, sw_sync_reg};
            REG_STATUS: read_data = status_word;
            REG_CYCLE:  read_data = cycle_reg;
            default:    read_data = '0;
        endcase
    end

endmodule

// File: doc/data_mem_io.md
Name: data_mem_io

Overview:
- Downstream data-side stage of the single-cycle processor.
- Consumes processor outputs mem_write, alu_result (used as address) and write_data; returns read_data to the processor in the same cycle.
- Maps a word RAM plus memory-mapped I/O: LED register, synchronised switches, byte TX FIFO with valid/ready output, and a free-running cycle counter.

Parameters:
RAM_WORDS, 256, number of 32-bit RAM words; power of two, at most 256
FIFO_DEPTH, 8, TX FIFO entries; power of two, at least 2

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
mem_write  input  1  store strobe from processor
address  input  32  byte address (processor alu_result)
write_data  input  32  store data from processor
read_data  output  32  load data to processor; combinational from address and current state
sw  input  16  asynchronous switch inputs
leds  output  16  LED register contents
tx_data  output  8  FIFO head byte
tx_valid  output  1  FIFO non-empty
tx_ready  input  1  consumer accepts tx_data when tx_valid && tx_ready

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst), applied on the rising edge.
- Memory map. address[1:0] is ignored; no misalignment fault.
  - 0x000-0x3FF: RAM, word index address[9:2].
  - 0x1000: LED (RW).
  - 0x1004: SW (RO).
  - 0x1008: TX_DATA (WO; reads 0).
  - 0x100C: STATUS (RW1-any-clears overflow).
  - 0x1010: CYCLE (RW; any write clears).
  - Address bits 31:13 must be zero for a hit. Unmapped or RAM index >= RAM_WORDS: reads 0, writes ignored.
- Reads are combinational, zero-latency. The single-cycle processor requires this; there is no registered read path.
- Writes take effect at the rising edge while mem_write=1; the new value is visible to reads the next cycle.
- Reset values:
  - RAM words 0.
  - leds 0.
  - FIFO empty, so tx_valid=0 and tx_data=0.
  - overflow 0.
  - CYCLE 0.
  - sw sync flops 0.
  - read_data is combinational from these, so reading RAM yields 0.
- RAM: write stores all 32 bits of write_data.
- LED: write loads write_data[15:0]. A read returns {16'b0, leds}.
- SW:
  - Two-flop synchroniser; a read returns {16'b0, sw_sync}.
  - A change on sw is readable 2 rising edges later.
- TX FIFO:
  - First-word fall-through; tx_data = head entry, tx_valid = count != 0.
  - Push: mem_write && address hits TX_DATA && !full. Pushes write_data[7:0].
  - Pop: tx_valid && tx_ready.
  - Push and pop in the same cycle, non-empty and not full: both happen, count unchanged, order preserved.
  - Push while full is dropped, even if a pop occurs in the same cycle. overflow is set to 1 (sticky).
  - Push into empty: tx_valid rises on the next cycle. A same-cycle tx_ready has no effect.
  - Read/write pointers wrap modulo FIFO_DEPTH.
  - tx_data must be held stable while tx_valid=1 and tx_ready=0.
- STATUS read value: {24'b0, count[4:0], overflow, full, empty}.
  - count sits at bits 7:3, sized for FIFO_DEPTH up to 16.
  - Any write to STATUS clears overflow. If an overflow event occurs in the same cycle, the set wins.
- CYCLE:
  - Increments by 1 every cycle and wraps from 0xFFFFFFFF to 0.
  - A write (any data) makes the next value 0; the clear has priority over the increment.
  - A read returns the current value.
- Reset asserted mid-transfer:
  - FIFO contents are discarded.
  - tx_valid drops at that edge.
  - Any mem_write in the reset cycle is ignored.

Decomposition:
- Package data_mem_io_pkg holds:
  - address constants: RAM_BASE, RAM_LIMIT, LED_ADDR, SW_ADDR, TX_DATA_ADDR, STATUS_ADDR, CYCLE_ADDR;
  - STATUS bit-position constants;
  - an enum for the decoded region (REG_RAM, REG_LED, REG_SW, REG_TX, REG_STATUS, REG_CYCLE, REG_NONE).
- One sub-module, sync_fifo, parameterised on width (8) and depth. It exposes push, pop, full, empty, count and head data.
- Address decode, RAM, registers, the synchroniser and the read mux stay in data_mem_io.

Test Plan:
1. Reset, then write 0xDEADBEEF to 0x010, then read 0x010 -> read_data=0xDEADBEEF. Read 0x014 -> 0. Read 0x2000 -> 0, and a write there changes nothing.
2. Write 0x0001ABCD to 0x1000 -> leds=16'hABCD next cycle; reading 0x1000 -> 0x0000ABCD. Set sw=16'h00F0 -> reading 0x1004 returns 0 for 1 cycle, then 0x000000F0 from the 2nd edge on.
3. With tx_ready=0, push 0x41,0x42,0x43 -> tx_valid=1, tx_data=0x41, STATUS count=3, empty=0. Raise tx_ready -> observed bytes 0x41,0x42,0x43 on consecutive cycles, then tx_valid=0.
4. With tx_ready=0, push 9 bytes into the 8-deep FIFO -> full=1, overflow=1, count=8, and the 9th byte is absent on drain. Write to STATUS -> overflow=0.
5. Hold tx_ready=1 while pushing every cycle into a FIFO with 2 entries -> count stays 2 and output order is preserved across pointer wrap.
6. Read CYCLE at two points 10 cycles apart -> difference=10. Write CYCLE -> it reads 0 the next cycle and 1 the cycle after. Assert rst mid-drain -> tx_valid=0 at that edge, and CYCLE, leds and RAM read 0.
